// File: rtl/bank_arbiter.sv
// Round-robin arbiter sharing one registered-read memory bank among NUM_REQ requesters.
// Grants and bank issue are combinational; read data is routed back to the owner one cycle later.
module bank_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PTR_W   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_data_in,
  output logic                        bank_read_enable,
  output logic                        bank_write_enable,
  input  logic [DATA_W-1:0]           bank_data_out
);

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] r_resp_owner;

  logic               w_found;
  logic               w_grant;
  logic [PTR_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_onehot;
  logic               w_we;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  // Scan from the pointer, wrapping through the power-of-two index space.
  always_comb begin : arb_scan
    logic [PTR_W-1:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = r_rr_ptr + PTR_W'(k);
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin : winner_mux
    w_grant  = w_found & ~reset;
    w_onehot = NUM_REQ'(1) << w_winner;
    w_we     = req_we[w_winner];
    w_addr   = req_addr[w_winner*ADDR_W +: ADDR_W];
    w_data   = req_data[w_winner*DATA_W +: DATA_W];
  end

  always_comb begin : issue_out
    req_ready         = '0;
    bank_addr         = '0;
    bank_data_in      = '0;
    bank_read_enable  = 1'b0;
    bank_write_enable = 1'b0;
    if (w_grant) begin
      req_ready         = w_onehot;
      bank_addr         = w_addr;
      bank_data_in      = w_data;
      bank_read_enable  = ~w_we;
      bank_write_enable = w_we;
    end
  end

  // A pending response is suppressed while reset is held, so a read granted just before reset is dropped.
  always_comb begin : resp_out
    resp_valid = reset ? '0 : r_resp_owner;
    resp_data  = (|resp_valid) ? bank_data_out : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_resp_owner <= '0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_winner + PTR_W'(1);
      end
      r_resp_owner <= (w_grant && !w_we) ? w_onehot : '0;
    end
  end

endmodule
